// File: rtl/sr_cfg_pkg.sv
// Shared types and constants for the dual-latch configuration chain sequencer.
package sr_cfg_pkg;

    localparam int DEF_BITS = 128;
    localparam int DEF_DIV  = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_CK1,
        S_GAP,
        S_CK2,
        S_LDGAP,
        S_LOAD,
        S_FIN
    } sr_seq_state_t;

    // Cycles from the start-accepting edge's cycle to the done pulse.
    function automatic int unsigned seq_cycles(input int unsigned bits,
                                               input int unsigned div,
                                               input logic        with_load);
        return 1 + 4 * div * bits + (with_load ? 2 * div : 0);
    endfunction

endpackage

// File: rtl/sr_phase_timer.sv
// Per-state phase timer: reloads to DIV-1 and flags the last cycle of a phase.
module sr_phase_timer #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic res,
    input  logic i_load,
    output logic o_tc
);

    localparam int TW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [TW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (res) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= TW'(DIV - 1);
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - TW'(1);
        end
    end

    assign o_tc = (r_cnt == '0);

endmodule

// File: rtl/sr_config_sequencer.sv
// Two-phase dual-latch config chain driver: shifts a captured word MSB-first,
// reads the previous chain contents back from sout, and optionally strobes ld.
module sr_config_sequencer
    import sr_cfg_pkg::*;
#(
    parameter int BITS = DEF_BITS,
    parameter int DIV  = DEF_DIV,
    parameter int CNTW = $clog2(BITS + 1)
) (
    input  logic            clk,
    input  logic            res,
    input  logic            start,
    input  logic            load_en,
    input  logic [BITS-1:0] cfg_data,
    output logic            ck1,
    output logic            ck2,
    output logic            sin,
    output logic            ld,
    input  logic            sout,
    output logic            busy,
    output logic            done,
    output logic [BITS-1:0] rb_data
);

    sr_seq_state_t   r_state;
    logic [BITS-1:0] r_shadow;
    logic [BITS-1:0] r_rb;
    logic [CNTW-1:0] r_bitcnt;
    logic            r_ld_q;
    logic [31:0]     r_run_len;

    logic            w_tc;
    logic            w_tmr_load;
    logic            w_last_bit;
    logic [BITS-1:0] w_shadow_nx;

    // Timer is held at DIV-1 while idle so SETUP starts with a full phase.
    assign w_tmr_load  = (r_state == S_IDLE) || w_tc;
    assign w_last_bit  = (r_bitcnt == CNTW'(BITS - 1));
    assign w_shadow_nx = r_shadow << 1;

    sr_phase_timer #(.DIV(DIV)) u_timer (
        .clk    (clk),
        .res    (res),
        .i_load (w_tmr_load),
        .o_tc   (w_tc)
    );

    always_ff @(posedge clk) begin
        if (res) begin
            r_state  <= S_IDLE;
            r_shadow <= '0;
            r_rb     <= '0;
            r_bitcnt <= '0;
            r_ld_q   <= 1'b0;
            ck1      <= 1'b0;
            ck2      <= 1'b0;
            sin      <= 1'b0;
            ld       <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            rb_data  <= '0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: if (start) begin
                    r_shadow <= cfg_data;
                    r_ld_q   <= load_en;
                    r_bitcnt <= '0;
                    sin      <= cfg_data[BITS-1];
                    busy     <= 1'b1;
                    r_state  <= S_SETUP;
                end
                S_SETUP: if (w_tc) begin
                    r_rb    <= {r_rb[BITS-2:0], sout};
                    ck1     <= 1'b1;
                    r_state <= S_CK1;
                end
                S_CK1: if (w_tc) begin
                    ck1     <= 1'b0;
                    r_state <= S_GAP;
                end
                S_GAP: if (w_tc) begin
                    ck2     <= 1'b1;
                    r_state <= S_CK2;
                end
                S_CK2: if (w_tc) begin
                    ck2      <= 1'b0;
                    r_shadow <= w_shadow_nx;
                    r_bitcnt <= r_bitcnt + CNTW'(1);
                    if (!w_last_bit) begin
                        sin     <= w_shadow_nx[BITS-1];
                        r_state <= S_SETUP;
                    end else if (r_ld_q) begin
                        r_state <= S_LDGAP;
                    end else begin
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        rb_data <= r_rb;
                        r_state <= S_FIN;
                    end
                end
                S_LDGAP: if (w_tc) begin
                    ld      <= 1'b1;
                    r_state <= S_LOAD;
                end
                S_LOAD: if (w_tc) begin
                    ld      <= 1'b0;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    rb_data <= r_rb;
                    r_state <= S_FIN;
                end
                S_FIN:   r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Sequence-length and non-overlap checks; r_run_len feeds nothing else.
    always_ff @(posedge clk) begin
        if (res || r_state == S_IDLE) begin
            r_run_len <= 32'd1;
        end else begin
            r_run_len <= r_run_len + 32'd1;
        end
        if (!res) begin
            assert (!(ck1 && ck2));
            if (done) begin
                assert (r_run_len == seq_cycles(BITS, DIV, r_ld_q));
            end
        end
    end

endmodule

// File: tb/tb_sr_config_sequencer.sv
// Bench for sr_config_sequencer: two instances (BITS=4/DIV=2 and BITS=2/DIV=1), each driving a dual-latch chain model.
module tb_sr_config_sequencer;
    import sr_cfg_pkg::*;

    localparam int B1 = 4;
    localparam int D1 = 2;
    localparam int B2 = 2;
    localparam int D2 = 1;

    typedef struct {
        int   cyc;
        int   nbusy;
        int   nld;
        int   ndone;
        int   done_at;
        int   ovl;
        int   badw;
        int   badsin;
        int   ra;
        int   rb;
        int   since;
        logic psin;
    } stats_t;

    typedef struct {
        logic [3:0] cfg;
        logic       le;
        logic [3:0] rb;
        logic [3:0] q;
        int         lat;
    } vec_t;

    logic clk = 1'b0;
    logic res = 1'b1;
    always #5 clk = ~clk;

    logic          start1 = 1'b0, le1 = 1'b0;
    logic [B1-1:0] cfg1 = '0;
    logic          ck1_1, ck2_1, sin1, ld1, sout1, busy1, done1;
    logic [B1-1:0] rb1;
    logic [B1-1:0] cm1 = '0, cs1 = '0, cq1 = '0;

    logic          start2 = 1'b0, le2 = 1'b0;
    logic [B2-1:0] cfg2 = '0;
    logic          ck1_2, ck2_2, sin2, ld2, sout2, busy2, done2;
    logic [B2-1:0] rb2;
    logic [B2-1:0] cm2 = '0, cs2 = '0, cq2 = '0;

    int         total = 0;
    int         bad   = 0;
    stats_t     s1, s2;
    logic [3:0] m_shift = '0;
    logic [3:0] m_q     = '0;

    sr_config_sequencer #(.BITS(B1), .DIV(D1)) u_dut1 (
        .clk(clk), .res(res), .start(start1), .load_en(le1), .cfg_data(cfg1),
        .ck1(ck1_1), .ck2(ck2_1), .sin(sin1), .ld(ld1), .sout(sout1),
        .busy(busy1), .done(done1), .rb_data(rb1)
    );

    sr_config_sequencer #(.BITS(B2), .DIV(D2)) u_dut2 (
        .clk(clk), .res(res), .start(start2), .load_en(le2), .cfg_data(cfg2),
        .ck1(ck1_2), .ck2(ck2_2), .sin(sin2), .ld(ld2), .sout(sout2),
        .busy(busy2), .done(done2), .rb_data(rb2)
    );

    // Dual-latch chain: ck1 loads masters from the previous slave (bit 0 from sin),
    // ck2 copies masters to slaves, ld transfers slaves to the parallel outputs.
    always @(posedge ck1_1) cm1 <= {cs1[B1-2:0], sin1};
    always @(posedge ck2_1) cs1 <= cm1;
    always @(posedge ld1)   cq1 <= cs1;
    assign sout1 = cs1[B1-1];

    always @(posedge ck1_2) cm2 <= {cs2[B2-2:0], sin2};
    always @(posedge ck2_2) cs2 <= cm2;
    always @(posedge ld2)   cq2 <= cs2;
    assign sout2 = cs2[B2-1];

    function automatic stats_t step(input stats_t s, input logic b, l, d, c1, c2, si, input int div);
        s.cyc += 1;
        if (b) s.nbusy += 1;
        if (l) s.nld += 1;
        if (d) begin
            s.ndone += 1;
            if (s.done_at == 0) s.done_at = s.cyc;
        end
        if (c1 && c2) s.ovl += 1;
        if (c1) s.ra += 1;
        else begin
            if (s.ra != 0 && s.ra != div) s.badw += 1;
            s.ra = 0;
        end
        if (c2) s.rb += 1;
        else begin
            if (s.rb != 0 && s.rb != div) s.badw += 1;
            s.rb = 0;
        end
        if (si !== s.psin) begin
            if (c1 || c2) s.badsin += 1;
            s.since = 0;
        end else begin
            s.since += 1;
        end
        if (c1 && s.ra == 1 && s.since < div) s.badsin += 1;
        s.psin = si;
        return s;
    endfunction

    function automatic stats_t clr(input stats_t s);
        stats_t r;
        r         = s;
        r.cyc     = 0;
        r.nbusy   = 0;
        r.nld     = 0;
        r.ndone   = 0;
        r.done_at = 0;
        r.ovl     = 0;
        r.badw    = 0;
        r.badsin  = 0;
        return r;
    endfunction

    always @(negedge clk) s1 = step(s1, busy1, ld1, done1, ck1_1, ck2_1, sin1, D1);
    always @(negedge clk) s2 = step(s2, busy2, ld2, done2, ck1_2, ck2_2, sin2, D2);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: readback returns what the previous sequence shifted in; outputs follow loads only.
    task automatic model1(input logic [3:0] c, input logic le, output logic [3:0] erb, output logic [3:0] eq);
        erb     = m_shift;
        m_shift = c;
        if (le) m_q = c;
        eq      = m_q;
    endtask

    task automatic run1(input logic [3:0] c, input logic le, input int stray,
                        input logic b2b, input logic [3:0] cn, input logic ln);
        @(negedge clk); #1;
        cfg1 = c; le1 = le; start1 = 1'b1; s1 = clr(s1);
        @(negedge clk); #1;
        start1 = 1'b0; cfg1 = ~c; le1 = ~le;
        for (int k = 1; k < 200 && s1.ndone == 0; k++) begin
            start1 = (k == stray);
            if (k == stray) cfg1 = cn;
            @(negedge clk); #1;
        end
        if (b2b) begin
            start1 = 1'b1; cfg1 = cn; le1 = ln;
        end else begin
            start1 = 1'b0;
            repeat (3) @(negedge clk);
        end
    endtask

    task automatic check1(input string t, input logic le, input logic [3:0] erb, input logic [3:0] eq, input int elat);
        chk({t, ".latency"},     s1.done_at, elat);
        chk({t, ".done_pulses"}, s1.ndone, 1);
        chk({t, ".busy_cycles"}, s1.nbusy, elat - 1);
        chk({t, ".ld_cycles"},   s1.nld, le ? D1 : 0);
        chk({t, ".overlap"},     s1.ovl, 0);
        chk({t, ".ck_width"},    s1.badw, 0);
        chk({t, ".sin_setup"},   s1.badsin, 0);
        chk({t, ".rb_data"},     rb1, erb);
        chk({t, ".q"},           cq1, eq);
    endtask

    task automatic run2(input logic [1:0] c, input logic le);
        @(negedge clk); #1;
        cfg2 = c; le2 = le; start2 = 1'b1; s2 = clr(s2);
        @(negedge clk); #1;
        start2 = 1'b0; cfg2 = ~c; le2 = ~le;
        for (int k = 0; k < 100 && s2.ndone == 0; k++) @(negedge clk);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad + 1);
        $display("test done: total=%0d bad=%0d", total + 1, bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       tbl[4];
        logic [3:0] erb, eq, c;
        logic       le;

        s1.psin = 1'b0;
        s2.psin = 1'b0;
        tbl[0] = '{cfg: 4'b1011, le: 1'b1, rb: 4'b0000, q: 4'b1011, lat: 37};
        tbl[1] = '{cfg: 4'b0110, le: 1'b0, rb: 4'b1011, q: 4'b1011, lat: 33};
        tbl[2] = '{cfg: 4'b0001, le: 1'b1, rb: 4'b0110, q: 4'b0001, lat: 37};
        tbl[3] = '{cfg: 4'b1110, le: 1'b1, rb: 4'b0001, q: 4'b1110, lat: 37};

        res = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset.dut1_outs", {ck1_1, ck2_1, ld1, sin1, busy1, done1}, 0);
        chk("reset.dut1_rb",   rb1, 0);
        chk("reset.dut2_outs", {ck1_2, ck2_2, ld2, sin2, busy2, done2}, 0);
        #1 res = 1'b0;

        foreach (tbl[i]) begin
            run1(tbl[i].cfg, tbl[i].le, 0, 1'b0, 4'b0, 1'b0);
            model1(tbl[i].cfg, tbl[i].le, erb, eq);
            check1($sformatf("vec%0d", i), tbl[i].le, tbl[i].rb, tbl[i].q, tbl[i].lat);
        end

        for (int i = 0; i < 8; i++) begin
            c  = 4'($urandom_range(0, 15));
            le = 1'($urandom_range(0, 1));
            run1(c, le, 0, 1'b0, 4'b0, 1'b0);
            model1(c, le, erb, eq);
            check1($sformatf("rnd%0d", i), le, erb, eq, int'(seq_cycles(B1, D1, le)));
        end

        // A second start 5 cycles into the run must be ignored.
        run1(4'b0101, 1'b1, 5, 1'b0, 4'b1010, 1'b0);
        model1(4'b0101, 1'b1, erb, eq);
        check1("busy_rej", 1'b1, erb, eq, 37);

        // Start held from the FIN cycle into the following IDLE cycle.
        run1(4'b0011, 1'b0, 0, 1'b1, 4'b1100, 1'b1);
        model1(4'b0011, 1'b0, erb, eq);
        check1("b2b_first", 1'b0, erb, eq, 33);
        @(negedge clk);
        chk("b2b.busy_after_fin", busy1, 0);
        #1 s1 = clr(s1);
        @(negedge clk);
        chk("b2b.busy_rise", busy1, 1);
        #1 start1 = 1'b0;
        for (int k = 0; k < 200 && s1.ndone == 0; k++) @(negedge clk);
        repeat (3) @(negedge clk);
        model1(4'b1100, 1'b1, erb, eq);
        check1("b2b_second", 1'b1, erb, eq, 37);

        run2(2'b10, 1'b1);
        chk("div1.latency",     s2.done_at, 11);
        chk("div1.done_pulses", s2.ndone, 1);
        chk("div1.ck_width",    s2.badw, 0);
        chk("div1.sin_setup",   s2.badsin, 0);
        chk("div1.overlap",     s2.ovl, 0);
        chk("div1.ld_cycles",   s2.nld, D2);
        chk("div1.q",           cq2, 2'b10);
        chk("div1.rb_data",     rb2, 2'b00);
        run2(2'b01, 1'b0);
        chk("div1_rb.latency",  s2.done_at, 9);
        chk("div1_rb.rb_data",  rb2, 2'b10);
        chk("div1_rb.q",        cq2, 2'b10);
        chk("div1_rb.ld_cycles", s2.nld, 0);
        chk("div1_rb.sin_setup", s2.badsin, 0);

        // Reset in the middle of a sequence.
        @(negedge clk); #1;
        cfg1 = 4'b1001; le1 = 1'b1; start1 = 1'b1;
        @(negedge clk); #1;
        start1 = 1'b0;
        repeat (10) @(negedge clk);
        #1 res = 1'b1;
        @(negedge clk);
        chk("midreset.outs", {ck1_1, ck2_1, ld1, sin1, busy1, done1}, 0);
        chk("midreset.rb",   rb1, 0);
        repeat (2) @(negedge clk);
        #1 res = 1'b0;
        s1 = clr(s1);
        repeat (80) @(negedge clk);
        chk("midreset.no_done", s1.ndone, 0);
        chk("midreset.no_busy", s1.nbusy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
